nt_subcircuit_bist_ctrl: RTL

Built-in self-test sequencer for one Nt-node benchmark subcircuit (DFFARX1-based, single output, active-low reset).
- Drives pseudo-random input vectors from an LFSR into the subcircuit and controls its reset.
- Compacts the subcircuit's single output into a MISR signature and compares it against a golden value.
- One instance sits beside each subcircuit under test in the trojan-detection harness.

---
 rtl/nt_subcircuit_bist_ctrl_if.sv | 32 +++
 rtl/nt_subcircuit_bist_ctrl.sv | 125 ++++++++++++
 2 files changed

// File: rtl/nt_subcircuit_bist_ctrl_if.sv
// Handshake/bus bundle between the BIST sequencer and its harness.
//   start, abort      : run control from the harness
//   golden_sig        : expected 16-bit signature
//   dut_out           : single output of the subcircuit under test
//   dut_in, dut_rst_n : stimulus vector and active-low reset to the subcircuit
//   busy, done, pass  : run status
//   signature         : current MISR contents
// master = harness side, slave = sequencer side.
interface nt_subcircuit_bist_ctrl_if #(
  parameter int unsigned N_IN = 7
);
  logic            start;
  logic            abort;
  logic [15:0]     golden_sig;
  logic            dut_out;
  logic [N_IN-1:0] dut_in;
  logic            dut_rst_n;
  logic            busy;
  logic            done;
  logic            pass;
  logic [15:0]     signature;

  modport master (
    output start, abort, golden_sig, dut_out,
    input  dut_in, dut_rst_n, busy, done, pass, signature
  );

  modport slave (
    input  start, abort, golden_sig, dut_out,
    output dut_in, dut_rst_n, busy, done, pass, signature
  );
endinterface

// File: rtl/nt_subcircuit_bist_ctrl.sv
// BIST sequencer for one benchmark subcircuit.
// Resets the subcircuit, drives LFSR vectors into it, compacts its single output into a
// 16-bit MISR and compares the result against a golden signature.
// Ports:
//   I1470_clk : clock, rising edge
//   I1477_rst : asynchronous reset, active-high
//   bus       : nt_subcircuit_bist_ctrl_if.slave (start/abort/golden_sig/dut_out in;
//               dut_in/dut_rst_n/busy/done/pass/signature out)
module nt_subcircuit_bist_ctrl #(
  parameter int unsigned N_IN        = 7,
  parameter int unsigned N_PAT       = 1000,
  parameter int unsigned LAT         = 2,
  parameter logic [15:0] SEED        = 16'hACE1,
  parameter int unsigned DUT_RST_CYC = 2
) (
  input logic                       I1470_clk,
  input logic                       I1477_rst,
  nt_subcircuit_bist_ctrl_if.slave  bus
);

  localparam int unsigned CntW    = 17;
  // An all-zero seed would lock the LFSR at zero.
  localparam logic [15:0] SeedEff = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam logic [CntW-1:0] RstLast = CntW'(DUT_RST_CYC - 1);
  localparam logic [CntW-1:0] RunLast = CntW'(N_PAT + LAT - 1);
  localparam logic [CntW-1:0] PatEnd  = CntW'(N_PAT);
  localparam logic [CntW-1:0] LatCnt  = CntW'(LAT);

  typedef enum logic [1:0] {StIdle, StRstDut, StRun, StCmp} state_e;

  state_e          state_q, state_d;
  logic [15:0]     lfsr_q, lfsr_d;
  logic [15:0]     misr_q, misr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            pass_q, pass_d;
  logic            done_q, done_d;

  logic [15:0] lfsr_step;
  logic [15:0] misr_step;

  assign lfsr_step = (lfsr_q >> 1) ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
  assign misr_step = {misr_q[14:0], 1'b0} ^ (misr_q[15] ? 16'h1021 : 16'h0000)
                   ^ {15'b0, bus.dut_out};

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    misr_d  = misr_q;
    cnt_d   = cnt_q;
    pass_d  = pass_q;
    done_d  = 1'b0;
    // Abort beats everything, including a simultaneous start in IDLE; the partial MISR
    // and the previous pass verdict are left untouched.
    if (bus.abort) begin
      state_d = StIdle;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            state_d = StRstDut;
            misr_d  = '0;
            lfsr_d  = SeedEff;
            cnt_d   = '0;
          end
        end
        StRstDut: begin
          if (cnt_q == RstLast) begin
            state_d = StRun;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StRun: begin
          lfsr_d = lfsr_step;
          // Responses trail their vectors by LAT cycles, so the capture window is shifted.
          if (cnt_q >= LatCnt) begin
            misr_d = misr_step;
          end
          if (cnt_q == RunLast) begin
            state_d = StCmp;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StCmp: begin
          pass_d  = (misr_q == bus.golden_sig);
          done_d  = 1'b1;
          state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge I1470_clk or posedge I1477_rst) begin
    if (I1477_rst) begin
      state_q <= StIdle;
      lfsr_q  <= '0;
      misr_q  <= '0;
      cnt_q   <= '0;
      pass_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      misr_q  <= misr_d;
      cnt_q   <= cnt_d;
      pass_q  <= pass_d;
      done_q  <= done_d;
    end
  end

  // Subcircuit reset follows the controller reset asynchronously and is otherwise only
  // asserted while the sequencer holds it in RST_DUT.
  assign bus.dut_rst_n = ~I1477_rst & (state_q != StRstDut);
  assign bus.dut_in    = (state_q == StRun && cnt_q < PatEnd) ? lfsr_q[N_IN-1:0] : '0;
  assign bus.busy      = (state_q != StIdle);
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.signature = misr_q;

endmodule
